// File: rtl/fetch_pkg.sv
`default_nettype none
// =============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction fetch queue.
// Revision : 1.0
// =============================================================================
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [5:0]  OPC_SPECIAL      = 6'h00;
    localparam logic [5:0]  FUNCT_SYSCALL    = 6'h0c;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    function automatic logic is_syscall(input logic [31:0] instr);
        return (instr[31:26] == OPC_SPECIAL) && (instr[5:0] == FUNCT_SYSCALL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// =============================================================================
// Module   : fetch_fifo
// Purpose  : Synchronous in-order FIFO of fetch entries with flush and count.
// Revision : 1.0
// =============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t       mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW:0]        count_q;
    logic               do_pop;
    logic               do_push;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage carries no reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (!reset && !flush_i && do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// =============================================================================
// Module   : instr_fetch_queue
// Purpose  : Sequential PC fetch with credit-limited requests, in-order return
//            queue and redirect flush. Optional FETCH_SYSCALL_HALT_EN halts
//            fetch after a syscall word is enqueued.
// Revision : 1.0
// =============================================================================
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef FETCH_SYSCALL_HALT_EN
    ,
    output logic        fetch_halted
`endif
);

    localparam int               CW      = $clog2(DEPTH);
    localparam logic [CW+1:0]    c_DEPTH = (CW+2)'(DEPTH);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  enq_pc_q, enq_pc_d;
    logic [CW:0]  inflight_q, inflight_d;
    logic [CW:0]  discard_q, discard_d;
    logic [CW:0]  count;
    logic [CW+1:0] credits_used;
    logic [31:0]  redirect_pc_aligned;
    logic         w_unused_pc_lsbs;
    logic         halted;
    logic         req_fire;
    logic         resp_fire;
    logic         enq;
    logic         pop;
    fetch_entry_t enq_entry;
    fetch_entry_t head;

    assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};
    assign w_unused_pc_lsbs    = ^redirect_pc[1:0];

    assign credits_used   = {1'b0, count} + {1'b0, inflight_q};
    assign imem_req_valid = !reset && !redirect_valid && !halted
                            && (credits_used < c_DEPTH) && (discard_q == '0);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_fire = imem_resp_valid && (inflight_q != '0);
    assign enq       = resp_fire && !redirect_valid && (discard_q == '0) && !halted;
    assign enq_entry = '{pc: enq_pc_q, instr: imem_resp_data};

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

`ifdef FETCH_SYSCALL_HALT_EN
    logic halted_q, halted_d;

    always_comb begin
        halted_d = halted_q;
        if (redirect_valid) begin
            halted_d = 1'b0;
        end else if (enq && is_syscall(imem_resp_data)) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted       = halted_q;
    assign fetch_halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        enq_pc_d   = enq_pc_q;
        inflight_d = inflight_q + {{CW{1'b0}}, req_fire} - {{CW{1'b0}}, resp_fire};
        discard_d  = discard_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc_aligned;
            enq_pc_d   = redirect_pc_aligned;
            // Earlier discards are a subset of inflight, so every outstanding
            // response not returning this cycle becomes a discard.
            discard_d  = inflight_q - {{CW{1'b0}}, resp_fire};
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (enq) begin
                enq_pc_d = enq_pc_q + 32'd4;
            end
            if (resp_fire && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            enq_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            enq_pc_q   <= enq_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect_valid),
        .push_i      (enq),
        .push_data_i (enq_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_resp_valid && (inflight_q == '0)));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// =============================================================================
// Module   : tb_instr_fetch_queue
// Purpose  : Self-checking bench for instr_fetch_queue with a fixed-latency
//            memory model; honours FETCH_SYSCALL_HALT_EN.
// Revision : 1.0
// =============================================================================
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_SYSCALL_HALT_EN
    logic        fetch_halted;
`endif

    always #5 clk = ~clk;

    instr_fetch_queue u_dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc)
`ifdef FETCH_SYSCALL_HALT_EN
        ,
        .fetch_halted    (fetch_halted)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        int          lat;
        int          run;
        logic [31:0] rpc;
        logic [31:0] exp_pc0;
        logic [31:0] exp_pc1;
    } rvec_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          lat   = 1;
    logic        mem_rst;
    mreq_t       mq[$];
    logic [31:0] issued[$];
    int          issued_edge[$];
    logic [31:0] dpc[$];
    logic [31:0] dins[$];
    int          dedge[$];
    rvec_t       vecs[5];

    function automatic logic [31:0] word_at(input logic [31:0] a);
`ifdef FETCH_SYSCALL_HALT_EN
        if (a == 32'h0000_3008) return 32'h0000_000C;
`endif
        return ~a;
    endfunction

    function automatic logic [31:0] dget_pc(input int i);
        return (dpc.size() > i) ? dpc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] dget_ins(input int i);
        return (dins.size() > i) ? dins[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] iget(input int i);
        return (issued.size() > i) ? issued[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        issued.delete();
        issued_edge.delete();
        dpc.delete();
        dins.delete();
        dedge.delete();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model and monitor: sampled 1 unit after the falling edge so the
    // stimulus driven at the falling edge has settled.
    always begin
        @(negedge clk);
        #1;
        if (mem_rst) begin
            mq.delete();
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
            if (mq.size() > 0 && mq[0].due == cyc + 1) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = word_at(mq[0].addr);
                void'(mq.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{addr: imem_req_addr, due: cyc + 1 + lat});
                issued.push_back(imem_req_addr);
                issued_edge.push_back(cyc + 1);
            end
            if (!reset && out_valid && out_ready) begin
                dpc.push_back(out_pc);
                dins.push_back(out_instr);
                dedge.push_back(cyc + 1);
            end
        end
    end

    task automatic do_reset(input int l);
        @(negedge clk);
        reset          = 1'b1;
        mem_rst        = 1'b1;
        redirect_valid = 1'b0;
        lat            = l;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        mem_rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_deliv(input int n, input int budget, input string name);
        int k = 0;
        while (dpc.size() < n && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (dpc.size() < n) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d deliveries expected %0d", name, dpc.size(), n);
        end
    endtask

    initial begin
        vecs[0] = '{lat: 1, run: 6, rpc: 32'h0000_4000, exp_pc0: 32'h0000_4000, exp_pc1: 32'h0000_4004};
        vecs[1] = '{lat: 3, run: 8, rpc: 32'h0000_4000, exp_pc0: 32'h0000_4000, exp_pc1: 32'h0000_4004};
        vecs[2] = '{lat: 2, run: 7, rpc: 32'hFFFF_FFFC, exp_pc0: 32'hFFFF_FFFC, exp_pc1: 32'h0000_0000};
        vecs[3] = '{lat: 3, run: 5, rpc: 32'h0000_5003, exp_pc0: 32'h0000_5000, exp_pc1: 32'h0000_5004};
        vecs[4] = '{lat: 1, run: 3, rpc: 32'h0000_0000, exp_pc0: 32'h0000_0000, exp_pc1: 32'h0000_0004};

        reset           = 1'b1;
        mem_rst         = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        out_ready       = 1'b1;
        lat             = 1;

        repeat (3) @(negedge clk);
        #2;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);

        @(negedge clk);
        reset   = 1'b0;
        mem_rst = 1'b0;
        clear_logs();
        #2;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0000_3000);

        // Continuous stream, latency 1.
        wait_deliv(4, 40, "stream");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stream_addr%0d", i), iget(i), 32'h3000 + 32'(4 * i));
            check($sformatf("stream_pc%0d", i), dget_pc(i), 32'h3000 + 32'(4 * i));
            check($sformatf("stream_instr%0d", i), dget_ins(i), ~(32'h3000 + 32'(4 * i)));
        end
        check("stream_latency", 32'((dedge.size() > 0 && issued_edge.size() > 0) ? dedge[0] - issued_edge[0] : -1), 32'd2);

        // Back-pressure: credits cap outstanding + buffered at DEPTH.
        do_reset(1);
        out_ready = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        check("bp_issued", 32'(issued.size()), 32'd4);
        check("bp_req_valid", 32'(imem_req_valid), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head_pc", out_pc, 32'h0000_3000);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #2;
        check("bp_popped", 32'(dpc.size()), 32'd1);
        check("bp_req_after_pop", 32'(imem_req_valid), 32'd1);
        @(negedge clk);
        #2;
        check("bp_issued_after", 32'(issued.size()), 32'd5);
        check("bp_addr5", iget(4), 32'h0000_3010);
        check("bp_req_valid2", 32'(imem_req_valid), 32'd0);
        check("bp_head_pc2", out_pc, 32'h0000_3004);

        // Redirect vectors.
        for (int v = 0; v < 5; v++) begin
            do_reset(vecs[v].lat);
            out_ready = 1'b1;
            repeat (vecs[v].run) @(negedge clk);
            redirect_valid = 1'b1;
            redirect_pc    = vecs[v].rpc;
            @(negedge clk);
            redirect_valid = 1'b0;
            dpc.delete();
            dins.delete();
            dedge.delete();
            wait_deliv(2, 60, $sformatf("redir%0d", v));
            check($sformatf("redir%0d_pc0", v), dget_pc(0), vecs[v].exp_pc0);
            check($sformatf("redir%0d_instr0", v), dget_ins(0), ~vecs[v].exp_pc0);
            check($sformatf("redir%0d_pc1", v), dget_pc(1), vecs[v].exp_pc1);
            check($sformatf("redir%0d_instr1", v), dget_ins(1), ~vecs[v].exp_pc1);
        end

        // Back-to-back redirects: the second target wins.
        do_reset(3);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_6000;
        @(negedge clk);
        redirect_pc    = 32'h0000_7000;
        @(negedge clk);
        redirect_valid = 1'b0;
        dpc.delete();
        dins.delete();
        wait_deliv(2, 60, "b2b");
        check("b2b_pc0", dget_pc(0), 32'h0000_7000);
        check("b2b_pc1", dget_pc(1), 32'h0000_7004);

        // Reset mid-stream with requests outstanding.
        do_reset(2);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        reset   = 1'b1;
        mem_rst = 1'b1;
        #2;
        check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        #2;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_pc", out_pc, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        mem_rst   = 1'b0;
        out_ready = 1'b1;
        clear_logs();
        #2;
        check("mid_rst_req_addr", imem_req_addr, 32'h0000_3000);
        wait_deliv(1, 20, "mid_rst");
        check("mid_rst_pc0", dget_pc(0), 32'h0000_3000);

`ifdef FETCH_SYSCALL_HALT_EN
        do_reset(1);
        out_ready = 1'b1;
        repeat (15) @(negedge clk);
        #2;
        check("halt_flag", 32'(fetch_halted), 32'd1);
        check("halt_req_valid", 32'(imem_req_valid), 32'd0);
        check("halt_count", 32'(dpc.size()), 32'd3);
        check("halt_pc", dget_pc(2), 32'h0000_3008);
        check("halt_instr", dget_ins(2), 32'h0000_000C);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3100;
        @(negedge clk);
        redirect_valid = 1'b0;
        dpc.delete();
        dins.delete();
        #2;
        check("halt_cleared", 32'(fetch_halted), 32'd0);
        wait_deliv(1, 20, "halt_redir");
        check("halt_redir_pc", dget_pc(0), 32'h0000_3100);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
